// File: rtl/synth_pkg.sv
// Shared definitions for the voice scheduler slice.
//   - Datapath widths (phase accumulator, wavetable sample, mix accumulator).
//   - Pipeline-state encodings presented on o_pipeline_state.
//   - Scheduler FSM state type and the voice-table entry layout.
//   - Helpers: pipeline-state decode and saturation of the mix to a sample.
package synth_pkg;

    localparam int PHASE_W     = 24;
    localparam int SAMPLE_W    = 16;
    localparam int ACC_W       = 24;
    localparam int VOICE_W     = 8;
    localparam int WAVE_W      = 4;
    localparam int PHASE_OUT_W = 10;

    localparam logic [1:0] PIPE_READ      = 2'd0;
    localparam logic [1:0] PIPE_COMPUTE   = 2'd1;
    localparam logic [1:0] PIPE_WRITEBACK = 2'd2;
    localparam logic [1:0] PIPE_IDLE      = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_COMPUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_DONE      = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic                gate;
        logic [WAVE_W-1:0]   wave;
        logic [PHASE_W-1:0]  delta;
        logic [PHASE_W-1:0]  phase;
    } voice_entry_t;

    // Map an FSM state onto the externally visible pipeline stage code.
    function automatic logic [1:0] pipe_encode(input sched_state_e st);
        logic [1:0] code;
        case (st)
            ST_READ:      code = PIPE_READ;
            ST_COMPUTE:   code = PIPE_COMPUTE;
            ST_WRITEBACK: code = PIPE_WRITEBACK;
            default:      code = PIPE_IDLE;
        endcase
        return code;
    endfunction

    // Clamp a mix-accumulator value into the signed sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat_to_sample(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [ACC_W-1:0] hi_lim;
        logic signed [ACC_W-1:0] lo_lim;
        logic signed [SAMPLE_W-1:0] res;
        hi_lim = 24'sd32767;
        lo_lim = -24'sd32768;
        if (v > hi_lim) begin
            res = 16'sh7FFF;
        end else if (v < lo_lim) begin
            res = 16'sh8000;
        end else begin
            res = v[SAMPLE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/voice_state_ram.sv
// Voice table: one entry (gate, wave, delta, phase) per voice.
//   i_clk, i_reset : clock and synchronous active-high reset (clears every entry)
//   rd_addr/rd_data: asynchronous read port
//   wr_en/wr_addr/wr_data: synchronous write port
// The scheduler never reads and writes the same address in one cycle, so no
// read-during-write bypass is needed. Out-of-range addresses read as zero and
// are never written.
module voice_state_ram
    import synth_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] rd_addr,
    output voice_entry_t  rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  voice_entry_t  wr_data
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    voice_entry_t mem_r [DEPTH];

    // Table storage: full clear on reset, otherwise single-entry write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port with range guard for non-power-of-two depths.
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < DEPTH_L) begin
            rd_data = mem_r[rd_addr];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Voice scheduler: on each sample tick, sweeps all voices through a
// READ -> COMPUTE -> WRITEBACK wavetable pipeline, advances every voice phase,
// sums the samples of gated voices and presents a saturated mix.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_sample_tick           : starts a sweep (dropped with o_overrun if busy)
//   i_upd_* / o_upd_ready   : voice-update handshake, only taken while idle
//   o_voice_index, o_phase,
//   o_wave_select           : current voice presented to the wavetable
//   o_pipeline_state        : 0 read, 1 compute, 2 writeback, 3 idle/done
//   i_sample                : wavetable output, sampled in writeback
//   o_mix, o_mix_valid      : mixed sample and its one-cycle strobe
//   o_busy, o_overrun       : sweep in progress, dropped-tick pulse
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int MIX_SHIFT  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_sample_tick,
    input  logic                          i_upd_valid,
    output logic                          o_upd_ready,
    input  logic [VOICE_W-1:0]            i_upd_voice,
    input  logic [PHASE_W-1:0]            i_upd_delta,
    input  logic [WAVE_W-1:0]             i_upd_wave,
    input  logic                          i_upd_gate,
    output logic [VOICE_W-1:0]            o_voice_index,
    output logic [1:0]                    o_pipeline_state,
    output logic [PHASE_OUT_W-1:0]        o_phase,
    output logic [WAVE_W-1:0]             o_wave_select,
    input  logic signed [SAMPLE_W-1:0]    i_sample,
    output logic signed [SAMPLE_W-1:0]    o_mix,
    output logic                          o_mix_valid,
    output logic                          o_busy,
    output logic                          o_overrun
);

    localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VOICE_W-1:0] LAST_VOICE  = VOICE_W'(NUM_VOICES - 1);
    localparam logic [VOICE_W:0]   VOICE_LIMIT = (VOICE_W+1)'(NUM_VOICES);

    sched_state_e             state_r;
    sched_state_e             state_s;
    logic [VOICE_W-1:0]       voice_r;
    logic [VOICE_W-1:0]       next_voice_s;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  acc_shift_s;
    voice_entry_t             cur_r;

    logic                     load_s;
    logic                     clr_acc_s;
    logic                     wb_s;
    logic                     done_s;
    logic                     upd_ready_s;
    logic                     upd_write_s;

    logic [AW-1:0]            rd_addr_s;
    voice_entry_t             rd_data_s;
    logic                     wr_en_s;
    logic [AW-1:0]            wr_addr_s;
    voice_entry_t             wr_data_s;

    // A tick in the same cycle takes priority over an update.
    assign upd_ready_s = (state_r == ST_IDLE) && !i_sample_tick;
    assign o_upd_ready = upd_ready_s;
    // Out-of-range voices are handshaken but never written.
    assign upd_write_s = i_upd_valid && upd_ready_s &&
                         ({1'b0, i_upd_voice} < VOICE_LIMIT);
    assign acc_shift_s = acc_r >>> MIX_SHIFT;

    voice_state_ram #(
        .DEPTH (NUM_VOICES),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and per-state control strobes.
    always_comb begin
        state_s      = state_r;
        next_voice_s = voice_r;
        load_s       = 1'b0;
        clr_acc_s    = 1'b0;
        wb_s         = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_sample_tick) begin
                    state_s      = ST_READ;
                    next_voice_s = {VOICE_W{1'b0}};
                    load_s       = 1'b1;
                    clr_acc_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                state_s = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                wb_s = 1'b1;
                if (voice_r == LAST_VOICE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s      = ST_READ;
                    next_voice_s = voice_r + 8'd1;
                    load_s       = 1'b1;
                end
            end
            ST_DONE: begin
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Table port steering: sweep reads the next voice, idle reads the update
    // target so a gate-on can detect the 0->1 edge. Writeback and updates are
    // mutually exclusive because updates are only accepted in IDLE.
    always_comb begin
        rd_addr_s = next_voice_s[AW-1:0];
        wr_en_s   = 1'b0;
        wr_addr_s = voice_r[AW-1:0];
        wr_data_s = cur_r;
        if (upd_ready_s) begin
            rd_addr_s = i_upd_voice[AW-1:0];
        end else begin
            rd_addr_s = next_voice_s[AW-1:0];
        end
        if (wb_s) begin
            wr_en_s         = 1'b1;
            wr_addr_s       = voice_r[AW-1:0];
            wr_data_s       = cur_r;
            wr_data_s.phase = cur_r.phase + cur_r.delta;
        end else if (upd_write_s) begin
            wr_en_s         = 1'b1;
            wr_addr_s       = i_upd_voice[AW-1:0];
            wr_data_s.gate  = i_upd_gate;
            wr_data_s.wave  = i_upd_wave;
            wr_data_s.delta = i_upd_delta;
            if (i_upd_gate && !rd_data_s.gate) begin
                wr_data_s.phase = {PHASE_W{1'b0}};
            end else begin
                wr_data_s.phase = rd_data_s.phase;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Sweep datapath: current-voice capture and the mix accumulator.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            voice_r <= {VOICE_W{1'b0}};
            cur_r   <= '0;
            acc_r   <= {ACC_W{1'b0}};
        end else begin
            if (load_s) begin
                voice_r <= next_voice_s;
                cur_r   <= rd_data_s;
            end
            if (clr_acc_s) begin
                acc_r <= {ACC_W{1'b0}};
            end else if (wb_s && cur_r.gate) begin
                acc_r <= acc_r + ACC_W'(i_sample);
            end
        end
    end

    // Registered outputs; voice fields are loaded on entry to READ so they
    // stay stable through WRITEBACK of that voice.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_voice_index    <= {VOICE_W{1'b0}};
            o_phase          <= {PHASE_OUT_W{1'b0}};
            o_wave_select    <= {WAVE_W{1'b0}};
            o_pipeline_state <= PIPE_IDLE;
            o_mix            <= 16'sd0;
            o_mix_valid      <= 1'b0;
            o_busy           <= 1'b0;
            o_overrun        <= 1'b0;
        end else begin
            if (load_s) begin
                o_voice_index <= next_voice_s;
                o_phase       <= rd_data_s.phase[PHASE_W-1 -: PHASE_OUT_W];
                o_wave_select <= rd_data_s.wave;
            end
            if (done_s) begin
                o_mix <= sat_to_sample(acc_shift_s);
            end
            o_mix_valid      <= done_s;
            o_pipeline_state <= pipe_encode(state_s);
            o_busy           <= (state_s != ST_IDLE);
            o_overrun        <= i_sample_tick && (state_r != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

    localparam int NV        = 4;
    localparam int MS        = 0;
    localparam int SWEEP_CYC = 3*NV + 2;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_sample_tick = 1'b0;
    logic               i_upd_valid = 1'b0;
    logic               o_upd_ready;
    logic [7:0]         i_upd_voice = 8'd0;
    logic [23:0]        i_upd_delta = 24'd0;
    logic [3:0]         i_upd_wave = 4'd0;
    logic               i_upd_gate = 1'b0;
    logic [7:0]         o_voice_index;
    logic [1:0]         o_pipeline_state;
    logic [9:0]         o_phase;
    logic [3:0]         o_wave_select;
    logic signed [15:0] i_sample = 16'sd0;
    logic signed [15:0] o_mix;
    logic               o_mix_valid;
    logic               o_busy;
    logic               o_overrun;

    int checks = 0;
    int failures = 0;
    logic signed [15:0] exp_q[$];
    logic signed [15:0] mon_exp;
    bit gated [NV];

    voice_scheduler #(.NUM_VOICES(NV), .MIX_SHIFT(MS)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_sample_tick(i_sample_tick),
        .i_upd_valid(i_upd_valid), .o_upd_ready(o_upd_ready),
        .i_upd_voice(i_upd_voice), .i_upd_delta(i_upd_delta),
        .i_upd_wave(i_upd_wave), .i_upd_gate(i_upd_gate),
        .o_voice_index(o_voice_index), .o_pipeline_state(o_pipeline_state),
        .o_phase(o_phase), .o_wave_select(o_wave_select), .i_sample(i_sample),
        .o_mix(o_mix), .o_mix_valid(o_mix_valid), .o_busy(o_busy),
        .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    // Reference mix: sum of gated voices, arithmetic shift, clamp to 16 bits.
    function automatic logic signed [15:0] model_mix(input logic signed [15:0] s);
        longint sum;
        sum = 0;
        for (int v = 0; v < NV; v++) begin
            if (gated[v]) sum += longint'(s);
        end
        sum = sum >>> MS;
        if (sum > 32767) return 16'sh7FFF;
        else if (sum < -32768) return 16'sh8000;
        else return 16'(sum);
    endfunction

    // Scoreboard: every mix strobe must match the oldest expected value.
    always @(negedge i_clk) begin
        if (o_mix_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL mix_unexpected: o_mix_valid=1 (o_mix=%0d), required no pulse", o_mix);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_mix !== mon_exp) begin
                    failures++;
                    $display("FAIL mix_value: o_mix=%0d, required %0d", o_mix, mon_exp);
                end
            end
        end
    end

    task automatic upd(input int v, input logic [23:0] d, input logic [3:0] w, input logic g);
        @(negedge i_clk);
        i_upd_valid = 1'b1;
        i_upd_voice = 8'(v);
        i_upd_delta = d;
        i_upd_wave  = w;
        i_upd_gate  = g;
        if (v < NV) gated[v] = g;
        @(negedge i_clk);
        i_upd_valid = 1'b0;
    endtask

    task automatic sweep(input logic signed [15:0] smp);
        exp_q.push_back(model_mix(smp));
        @(negedge i_clk);
        i_sample = smp;
        i_sample_tick = 1'b1;
        @(negedge i_clk);
        i_sample_tick = 1'b0;
        repeat (SWEEP_CYC + 2) @(negedge i_clk);
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++; if (o_mix !== 16'sd0) begin failures++; $display("FAIL rst_mix: got %0d, required 0", o_mix); end
        checks++; if (o_mix_valid !== 1'b0) begin failures++; $display("FAIL rst_mix_valid: got %b, required 0", o_mix_valid); end
        checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun: got %b, required 0", o_overrun); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
        checks++; if (o_pipeline_state !== 2'd3) begin failures++; $display("FAIL rst_pipe: got %0d, required 3", o_pipeline_state); end
        checks++; if (o_voice_index !== 8'd0) begin failures++; $display("FAIL rst_voice: got %0d, required 0", o_voice_index); end
        checks++; if (o_phase !== 10'd0) begin failures++; $display("FAIL rst_phase: got %0h, required 0", o_phase); end
        checks++; if (o_wave_select !== 4'd0) begin failures++; $display("FAIL rst_wave: got %0h, required 0", o_wave_select); end
        i_reset = 1'b0;
        @(negedge i_clk);
        checks++; if (o_upd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b, required 1", o_upd_ready); end
    endtask

    task automatic test_latency;
        int first_valid;
        int n_valid;
        logic [1:0] exp_pipe;
        first_valid = -1;
        n_valid = 0;
        exp_q.push_back(model_mix(16'sd1234));
        @(negedge i_clk);
        i_sample = 16'sd1234;
        i_sample_tick = 1'b1;
        for (int cyc = 1; cyc <= SWEEP_CYC + 3; cyc++) begin
            @(negedge i_clk);
            i_sample_tick = 1'b0;
            #1;
            exp_pipe = (cyc <= 3*NV) ? 2'((cyc - 1) % 3) : 2'd3;
            checks++;
            if (o_pipeline_state !== exp_pipe) begin
                failures++;
                $display("FAIL lat_pipe cyc=%0d: got %0d, required %0d", cyc, o_pipeline_state, exp_pipe);
            end
            checks++;
            if (o_busy !== ((cyc <= 3*NV + 1) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL lat_busy cyc=%0d: got %b", cyc, o_busy);
            end
            if (cyc <= 3*NV) begin
                checks++;
                if (o_voice_index !== 8'((cyc - 1) / 3)) begin
                    failures++;
                    $display("FAIL lat_voice cyc=%0d: got %0d, required %0d", cyc, o_voice_index, (cyc - 1) / 3);
                end
            end
            if (o_mix_valid === 1'b1) begin
                n_valid++;
                if (first_valid < 0) first_valid = cyc;
            end
        end
        checks++; if (first_valid != SWEEP_CYC) begin failures++; $display("FAIL lat_cycles: got %0d, required %0d", first_valid, SWEEP_CYC); end
        checks++; if (n_valid != 1) begin failures++; $display("FAIL lat_pulses: got %0d, required 1", n_valid); end
    endtask

    task automatic test_single_voice;
        upd(1, 24'h000400, 4'h3, 1'b1);
        checks++; if (dut.u_ram.mem_r[1].delta !== 24'h000400) begin failures++; $display("FAIL upd_delta: got %h, required 000400", dut.u_ram.mem_r[1].delta); end
        checks++; if (dut.u_ram.mem_r[1].wave !== 4'h3) begin failures++; $display("FAIL upd_wave: got %h, required 3", dut.u_ram.mem_r[1].wave); end
        for (int k = 0; k < 3; k++) sweep(16'sd1000);
        checks++; if (dut.u_ram.mem_r[1].phase !== 24'h000C00) begin failures++; $display("FAIL v1_phase: got %h, required 000C00", dut.u_ram.mem_r[1].phase); end
    endtask

    task automatic test_saturation;
        upd(0, 24'h0, 4'h1, 1'b1);
        upd(2, 24'h0, 4'h2, 1'b1);
        upd(3, 24'h0, 4'h4, 1'b1);
        sweep(16'sd20000);
        sweep(-16'sd20000);
        sweep(16'sd5000);
        upd(0, 24'h0, 4'h1, 1'b0);
        sweep(16'sd5000);
    endtask

    task automatic test_overrun;
        int n_ovr;
        int first_ovr;
        int n_valid;
        int first_acc;
        n_ovr = 0; first_ovr = -1; n_valid = 0; first_acc = -1;
        i_upd_voice = 8'd2; i_upd_delta = 24'h0; i_upd_wave = 4'h0; i_upd_gate = 1'b0;
        exp_q.push_back(model_mix(16'sd1000));
        @(negedge i_clk);
        i_sample = 16'sd1000;
        i_sample_tick = 1'b1;
        for (int cyc = 1; cyc <= SWEEP_CYC + 4; cyc++) begin
            @(negedge i_clk);
            i_sample_tick = (cyc == 5) ? 1'b1 : 1'b0;
            i_upd_valid = (first_acc < 0) ? 1'b1 : 1'b0;
            #1;
            if (o_overrun === 1'b1) begin
                n_ovr++;
                if (first_ovr < 0) first_ovr = cyc;
            end
            if (o_mix_valid === 1'b1) n_valid++;
            if (i_upd_valid && o_upd_ready === 1'b1 && first_acc < 0) first_acc = cyc;
        end
        gated[2] = 1'b0;
        checks++; if (n_ovr != 1) begin failures++; $display("FAIL ovr_pulses: got %0d, required 1", n_ovr); end
        checks++; if (first_ovr != 6) begin failures++; $display("FAIL ovr_cycle: got %0d, required 6", first_ovr); end
        checks++; if (n_valid != 1) begin failures++; $display("FAIL ovr_mix_pulses: got %0d, required 1", n_valid); end
        checks++; if (first_acc != SWEEP_CYC) begin failures++; $display("FAIL ovr_upd_accept: got %0d, required %0d", first_acc, SWEEP_CYC); end
        checks++; if (dut.u_ram.mem_r[2].gate !== 1'b0) begin failures++; $display("FAIL ovr_upd_gate: got %b, required 0", dut.u_ram.mem_r[2].gate); end
        sweep(16'sd1000);
    endtask

    task automatic test_wrap;
        upd(3, 24'hFFFFF0, 4'h5, 1'b0);
        upd(3, 24'hFFFFF0, 4'h5, 1'b1);
        sweep(16'sd100);
        checks++; if (dut.u_ram.mem_r[3].phase !== 24'hFFFFF0) begin failures++; $display("FAIL wrap_phase1: got %h, required FFFFF0", dut.u_ram.mem_r[3].phase); end
        upd(3, 24'hFFFFFF, 4'h5, 1'b1);
        checks++; if (dut.u_ram.mem_r[3].phase !== 24'hFFFFF0) begin failures++; $display("FAIL retune_phase: got %h, required FFFFF0", dut.u_ram.mem_r[3].phase); end
        sweep(16'sd100);
        checks++; if (dut.u_ram.mem_r[3].phase !== 24'hFFFFEF) begin failures++; $display("FAIL wrap_phase2: got %h, required FFFFEF", dut.u_ram.mem_r[3].phase); end
        @(negedge i_clk);
        i_upd_valid = 1'b1; i_upd_voice = 8'd9; i_upd_delta = 24'hABCDEF; i_upd_wave = 4'hF; i_upd_gate = 1'b0;
        #1;
        checks++; if (o_upd_ready !== 1'b1) begin failures++; $display("FAIL oor_ready: got %b, required 1", o_upd_ready); end
        @(negedge i_clk);
        i_upd_valid = 1'b0;
        checks++; if (dut.u_ram.mem_r[1].gate !== 1'b1) begin failures++; $display("FAIL oor_gate: got %b, required 1", dut.u_ram.mem_r[1].gate); end
        checks++; if (dut.u_ram.mem_r[1].delta !== 24'h000400) begin failures++; $display("FAIL oor_delta: got %h, required 000400", dut.u_ram.mem_r[1].delta); end
        checks++; if (dut.u_ram.mem_r[1].wave !== 4'h3) begin failures++; $display("FAIL oor_wave: got %h, required 3", dut.u_ram.mem_r[1].wave); end
        sweep(16'sd300);
        upd(3, 24'hFFFFFF, 4'h5, 1'b0);
        upd(3, 24'hFFFFFF, 4'h5, 1'b1);
        checks++; if (dut.u_ram.mem_r[3].phase !== 24'h000000) begin failures++; $display("FAIL gate_on_clear: got %h, required 000000", dut.u_ram.mem_r[3].phase); end
    endtask

    task automatic test_reset_mid;
        @(negedge i_clk);
        i_sample = 16'sd700;
        i_sample_tick = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge i_clk);
            i_sample_tick = 1'b0;
        end
        checks++; if (o_pipeline_state !== 2'd1 || o_voice_index !== 8'd2) begin
            failures++; $display("FAIL mid_position: pipe=%0d voice=%0d, required pipe=1 voice=2", o_pipeline_state, o_voice_index);
        end
        i_reset = 1'b1;
        @(negedge i_clk);
        checks++; if (o_pipeline_state !== 2'd3) begin failures++; $display("FAIL mid_rst_pipe: got %0d, required 3", o_pipeline_state); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %b, required 0", o_busy); end
        checks++; if (o_mix !== 16'sd0 || o_mix_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_mix: got %0d/%b, required 0/0", o_mix, o_mix_valid); end
        checks++; if (o_voice_index !== 8'd0 || o_phase !== 10'd0 || o_wave_select !== 4'd0) begin
            failures++; $display("FAIL mid_rst_voice: got %0d/%h/%h, required 0/0/0", o_voice_index, o_phase, o_wave_select);
        end
        i_reset = 1'b0;
        for (int v = 0; v < NV; v++) begin
            gated[v] = 1'b0;
            checks++;
            if (dut.u_ram.mem_r[v].gate !== 1'b0) begin failures++; $display("FAIL mid_gate v=%0d: got %b, required 0", v, dut.u_ram.mem_r[v].gate); end
        end
        repeat (SWEEP_CYC + 4) @(negedge i_clk);
        sweep(16'sd1000);
    endtask

    initial begin
        for (int v = 0; v < NV; v++) gated[v] = 1'b0;
        test_reset();
        test_latency();
        test_single_voice();
        test_saturation();
        test_overrun();
        test_wrap();
        test_reset_mid();
        repeat (4) @(negedge i_clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL mix_pending: %0d expected results never produced, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
